// File: rtl/super_pixel_pkg.sv
// Shared field layout, LFSR constants and Gray decode for the super-pixel column-end decoder.
package super_pixel_pkg;
    localparam int TS_W     = 9;
    localparam int FTOA_W   = 5;
    localparam int TOT_W    = 8;
    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 26;
    localparam int TOA_W    = 13;

    localparam int TS_LSB   = 17;
    localparam int FTOA_LSB = 12;
    localparam int TOT_LSB  = 4;
    localparam int ADDR_LSB = 0;

    localparam logic [FTOA_W-1:0] LFSR5_SEED = 5'b11111;
    localparam logic [FTOA_W-1:0] LFSR5_TAPS = 5'b10100;
    localparam logic [TOT_W-1:0]  LFSR8_SEED = 8'hFF;
    localparam logic [TOT_W-1:0]  LFSR8_TAPS = 8'b1011_1000;
    localparam int LFSR5_MAX = 31;
    localparam int LFSR8_MAX = 255;

    function automatic logic [TS_W-1:0] gray2bin(input logic [TS_W-1:0] g);
        logic [TS_W-1:0] b;
        b = '0;
        b[TS_W-1] = g[TS_W-1];
        for (int i = TS_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction
endpackage

// File: rtl/super_pixel_readout_decoder_lfsr_search.sv
// Serial LFSR-to-binary search: steps a local LFSR from SEED until it equals the target,
// reporting the step count, or flags an error after MAXCNT fruitless steps.
module lfsr_search #(
    parameter int           W      = 5,
    parameter logic [W-1:0] SEED   = '1,
    parameter logic [W-1:0] TAPS   = '1,
    parameter int           MAXCNT = 31
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_start,
    input  logic [W-1:0] i_target,
    output logic         o_done,
    output logic         o_err,
    output logic [W-1:0] o_count
);
    localparam logic [W-1:0] LP_MAX = W'(MAXCNT);

    logic [W-1:0] r_lfsr;
    logic [W-1:0] r_count;
    logic         r_done;
    logic         r_err;
    logic         w_fb;

    assign w_fb = ^(r_lfsr & TAPS);

    // Idle with done set so nothing runs until the first start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr  <= SEED;
            r_count <= '0;
            r_done  <= 1'b1;
            r_err   <= 1'b0;
        end else if (i_start) begin
            r_lfsr  <= SEED;
            r_count <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else if (!r_done) begin
            if (r_lfsr == i_target) begin
                r_done <= 1'b1;
            end else if (r_count == LP_MAX) begin
                r_done  <= 1'b1;
                r_err   <= 1'b1;
                r_count <= '0;
            end else begin
                r_lfsr  <= {r_lfsr[W-2:0], w_fb};
                r_count <= r_count + W'(1);
            end
        end
    end

    assign o_done  = r_done;
    assign o_err   = r_err;
    assign o_count = r_count;
endmodule

// File: rtl/super_pixel_readout_decoder.sv
// Column-end receiver: takes one arbiter word per handshake, decodes Gray/LFSR fields
// and presents one decoded hit on a valid/ready port.
//   state  | meaning
//   IDLE   | ready toward chain, waiting for a word
//   SEARCH | both LFSR searches running
//   HOLD   | decoded hit presented, waiting for dec_ready
module super_pixel_readout_decoder
    import super_pixel_pkg::*;
(
    input  logic              clk_40MHz,
    input  logic              rst_n,
    input  logic              i_shake_hands_last,
    input  logic [DATA_W-1:0] i_arbiter_data,
    output logic              o_shake_hands_next,
    output logic              o_dec_valid,
    input  logic              i_dec_ready,
    output logic [TS_W-1:0]   o_dec_ts,
    output logic [FTOA_W-1:0] o_dec_ftoa,
    output logic [TOT_W-1:0]  o_dec_tot,
    output logic [TOA_W-1:0]  o_dec_toa_fine,
    output logic [ADDR_W-1:0] o_dec_addr,
    output logic              o_dec_err
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SEARCH = 2'd1;
    localparam logic [1:0] S_HOLD   = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_shn;
    logic [DATA_W-1:0] r_word;
    logic              w_take;
    logic              w_valid;
    logic              w_ftoa_done, w_ftoa_err;
    logic              w_tot_done, w_tot_err;
    logic [FTOA_W-1:0] w_ftoa_cnt;
    logic [TOT_W-1:0]  w_tot_cnt;
    logic [TS_W-1:0]   w_ts_bin;
    logic [TOA_W-1:0]  w_toa;

    assign w_take = (r_state == S_IDLE) && r_shn && i_shake_hands_last;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_take) w_state_nxt = S_SEARCH;
            S_SEARCH: if (w_ftoa_done && w_tot_done) w_state_nxt = S_HOLD;
            S_HOLD:   if (i_dec_ready) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Ready is registered from the next state, so dec_ready never reaches it combinationally.
    always_ff @(posedge clk_40MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_shn   <= 1'b0;
            r_word  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_shn   <= (w_state_nxt == S_IDLE);
            if (w_take) r_word <= i_arbiter_data;
        end
    end

    lfsr_search #(
        .W(FTOA_W), .SEED(LFSR5_SEED), .TAPS(LFSR5_TAPS), .MAXCNT(LFSR5_MAX)
    ) u_ftoa_search (
        .clk(clk_40MHz), .rst_n(rst_n), .i_start(w_take),
        .i_target(r_word[FTOA_LSB +: FTOA_W]),
        .o_done(w_ftoa_done), .o_err(w_ftoa_err), .o_count(w_ftoa_cnt)
    );

    lfsr_search #(
        .W(TOT_W), .SEED(LFSR8_SEED), .TAPS(LFSR8_TAPS), .MAXCNT(LFSR8_MAX)
    ) u_tot_search (
        .clk(clk_40MHz), .rst_n(rst_n), .i_start(w_take),
        .i_target(r_word[TOT_LSB +: TOT_W]),
        .o_done(w_tot_done), .o_err(w_tot_err), .o_count(w_tot_cnt)
    );

    assign w_ts_bin = gray2bin(r_word[TS_LSB +: TS_W]);
    assign w_toa    = {w_ts_bin, 4'b0000} - 13'd16 - {8'b0, w_ftoa_cnt};
    assign w_valid  = (r_state == S_HOLD);

    // Outputs are zeroed outside HOLD so reset and idle both read as all-zero.
    assign o_shake_hands_next = r_shn;
    assign o_dec_valid        = w_valid;
    assign o_dec_ts           = w_valid ? w_ts_bin : '0;
    assign o_dec_ftoa         = w_valid ? w_ftoa_cnt : '0;
    assign o_dec_tot          = w_valid ? w_tot_cnt : '0;
    assign o_dec_toa_fine     = w_valid ? w_toa : '0;
    assign o_dec_addr         = w_valid ? r_word[ADDR_LSB +: ADDR_W] : '0;
    assign o_dec_err          = w_valid & (w_ftoa_err | w_tot_err);
endmodule

// File: tb/tb_super_pixel_readout_decoder.sv
// Directed, table-driven bench for super_pixel_readout_decoder.
module tb_super_pixel_readout_decoder;
    logic        clk_40MHz = 1'b0;
    logic        rst_n = 1'b0;
    logic        shl = 1'b0;
    logic [25:0] arb = '0;
    logic        dec_ready = 1'b0;
    logic        shn, dec_valid, dec_err;
    logic [8:0]  dec_ts;
    logic [4:0]  dec_ftoa;
    logic [7:0]  dec_tot;
    logic [12:0] dec_toa;
    logic [3:0]  dec_addr;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_40MHz = ~clk_40MHz;

    super_pixel_readout_decoder dut (
        .clk_40MHz(clk_40MHz), .rst_n(rst_n),
        .i_shake_hands_last(shl), .i_arbiter_data(arb),
        .o_shake_hands_next(shn), .o_dec_valid(dec_valid), .i_dec_ready(dec_ready),
        .o_dec_ts(dec_ts), .o_dec_ftoa(dec_ftoa), .o_dec_tot(dec_tot),
        .o_dec_toa_fine(dec_toa), .o_dec_addr(dec_addr), .o_dec_err(dec_err)
    );

    typedef struct {
        logic [25:0] word;
        logic [8:0]  e_ts;
        logic [4:0]  e_ftoa;
        logic [7:0]  e_tot;
        logic [12:0] e_toa;
        logic [3:0]  e_addr;
        logic        e_err;
        int          e_lat;
    } vec_t;

    localparam int NV = 7 + 31 * 4;
    vec_t vecs[NV];

    task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    function automatic logic [4:0] code5(input int k);
        logic [4:0] q = 5'b11111;
        for (int i = 0; i < k; i++) q = {q[3:0], q[4] ^ q[2]};
        return q;
    endfunction

    function automatic logic [7:0] code8(input int k);
        logic [7:0] q = 8'hFF;
        for (int i = 0; i < k; i++) q = {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
        return q;
    endfunction

    // fk/tk < 0 selects the all-zero code, which is absent from both sequences.
    function automatic vec_t mk(input int ts, input int fk, input int tk, input int addr);
        vec_t v;
        logic [8:0] b;
        int nf, nt;
        b = 9'(ts);
        v.e_ts   = b;
        v.e_ftoa = (fk < 0) ? 5'd0 : 5'(fk);
        v.e_tot  = (tk < 0) ? 8'd0 : 8'(tk);
        v.e_addr = 4'(addr);
        v.e_err  = (fk < 0) || (tk < 0);
        v.word   = {b ^ (b >> 1), (fk < 0) ? 5'b00000 : code5(fk),
                    (tk < 0) ? 8'h00 : code8(tk), 4'(addr)};
        v.e_toa  = 13'((((ts * 16 - 16 - int'(v.e_ftoa)) % 8192) + 8192) % 8192);
        nf = (fk < 0) ? 31 : fk;
        nt = (tk < 0) ? 255 : tk;
        v.e_lat  = ((nf > nt) ? nf : nt) + 2;
        return v;
    endfunction

    task automatic launch(input logic [25:0] word, input int idx);
        for (int i = 0; i < 20 && shn !== 1'b1; i++) @(negedge clk_40MHz);
        chk("shn_ready", idx, shn, 1);
        arb = word;
        shl = 1'b1;
        @(posedge clk_40MHz);
        #1;
        shl = 1'b0;
        chk("shn_low_after_take", idx, shn, 0);
    endtask

    task automatic collect(input vec_t v, input int idx, input bit release_hit);
        int lat = 0;
        while (dec_valid !== 1'b1 && lat < 400) begin
            @(posedge clk_40MHz);
            #1;
            lat++;
        end
        chk("latency", idx, lat, v.e_lat);
        chk("dec_ts", idx, dec_ts, v.e_ts);
        chk("dec_ftoa", idx, dec_ftoa, v.e_ftoa);
        chk("dec_tot", idx, dec_tot, v.e_tot);
        chk("dec_toa_fine", idx, dec_toa, v.e_toa);
        chk("dec_addr", idx, dec_addr, v.e_addr);
        chk("dec_err", idx, dec_err, v.e_err);
        if (release_hit) begin
            @(negedge clk_40MHz);
            dec_ready = 1'b1;
            @(posedge clk_40MHz);
            #1;
            dec_ready = 1'b0;
            chk("valid_drop", idx, dec_valid, 0);
            chk("shn_after_accept", idx, shn, 1);
            @(negedge clk_40MHz);
        end
    endtask

    initial begin
        vec_t va, vb, vr, vn;
        int n = 0;

        vecs[n++] = mk(3, 1, 1, 5);
        vecs[n++] = mk(0, 2, 0, 6);
        vecs[n++] = mk(0, 0, 0, 7);
        vecs[n++] = mk(44, -1, 3, 8);
        vecs[n++] = mk(200, 5, -1, 9);
        vecs[n++] = mk(511, -1, -1, 10);
        vecs[n++] = mk(300, 30, 254, 11);
        for (int f = 0; f < 31; f++) begin
            vecs[n++] = mk((f * 37) % 512, f, 0, f % 16);
            vecs[n++] = mk((f * 37 + 1) % 512, f, 7, (f + 1) % 16);
            vecs[n++] = mk((f * 37 + 2) % 512, f, 100, (f + 2) % 16);
            vecs[n++] = mk((f * 37 + 3) % 512, f, 254, (f + 3) % 16);
        end

        // Reset values.
        repeat (3) @(posedge clk_40MHz);
        #1;
        chk("rst_shn", 0, shn, 0);
        chk("rst_valid", 0, dec_valid, 0);
        chk("rst_outputs", 0, {dec_ts, dec_ftoa, dec_tot, dec_toa, dec_addr, dec_err}, 0);
        @(negedge clk_40MHz);
        rst_n = 1'b1;
        @(posedge clk_40MHz);
        #1;
        chk("shn_first_edge", 0, shn, 1);
        chk("valid_first_edge", 0, dec_valid, 0);
        @(negedge clk_40MHz);

        // The literal word from the first directed example.
        chk("word0_literal", 0, vecs[0].word, {9'b000000010, 5'b11110, 8'hFE, 4'h5});

        for (int i = 0; i < NV; i++) begin
            launch(vecs[i].word, i);
            collect(vecs[i], i, 1'b1);
        end

        // Backpressure: second word held on the chain while HOLD stalls.
        va = mk(100, 2, 2, 9);
        vb = mk(77, 12, 40, 4);
        launch(va.word, 1000);
        collect(va, 1000, 1'b0);
        arb = vb.word;
        shl = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk_40MHz);
            #1;
            chk("bp_hold", c, {dec_valid, dec_ts, dec_ftoa, dec_tot, dec_toa, dec_addr, dec_err},
                {1'b1, va.e_ts, va.e_ftoa, va.e_tot, va.e_toa, va.e_addr, va.e_err});
            chk("bp_shn", c, shn, 0);
        end
        @(negedge clk_40MHz);
        dec_ready = 1'b1;
        @(posedge clk_40MHz);
        #1;
        dec_ready = 1'b0;
        chk("bp_accept_valid", 1001, dec_valid, 0);
        chk("bp_accept_shn", 1001, shn, 1);
        @(posedge clk_40MHz);
        #1;
        shl = 1'b0;
        chk("bp_second_taken", 1001, shn, 0);
        collect(vb, 1001, 1'b1);

        // Reset in the middle of a long search.
        vr = mk(5, 3, 200, 1);
        launch(vr.word, 2000);
        repeat (20) @(posedge clk_40MHz);
        @(negedge clk_40MHz);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 2000, dec_valid, 0);
        chk("midrst_shn", 2000, shn, 0);
        chk("midrst_outputs", 2000, {dec_ts, dec_ftoa, dec_tot, dec_toa, dec_addr, dec_err}, 0);
        repeat (2) @(negedge clk_40MHz);
        rst_n = 1'b1;
        vn = mk(7, 4, 6, 3);
        launch(vn.word, 2001);
        collect(vn, 2001, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
